// File: rtl/i2s_audio_port_if.sv
// Sample-side bus of i2s_audio_port: DAC pair handshake, underrun flag and ADC publish.
// master = audio peripheral logic, slave = the I2S port.
interface i2s_audio_port_if #(
  parameter int SAMPLE_W = 24
);
  logic [SAMPLE_W-1:0] dac_left;
  logic [SAMPLE_W-1:0] dac_right;
  logic                dac_valid;
  logic                dac_ready;
  logic                dac_underrun;
  logic [SAMPLE_W-1:0] adc_left;
  logic [SAMPLE_W-1:0] adc_right;
  logic                adc_valid;

  modport master (
    output dac_left, dac_right, dac_valid,
    input  dac_ready, dac_underrun, adc_left, adc_right, adc_valid
  );

  modport slave (
    input  dac_left, dac_right, dac_valid,
    output dac_ready, dac_underrun, adc_left, adc_right, adc_valid
  );
endinterface

// File: rtl/i2s_audio_port.sv
// I2S master: BCLK/LRCK generation, DAC serialiser with one-pair holding buffer, ADC deserialiser.
// Optional macro I2S_LOOPBACK_EN adds a 'loopback' input that feeds aud_dacdat into the capture path.
module i2s_audio_port #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  i2s_audio_port_if.slave  bus,
`ifdef I2S_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             aud_bclk,
  output logic             aud_lrck,
  output logic             aud_dacdat,
  input  logic             aud_adcdat
);

  localparam int CW = $clog2(2 * SLOT_W);
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SLOT_C   = CW'(SLOT_W);
  localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_W);

  logic [DW-1:0]       div_q, div_d;
  logic                bclk_q, bclk_d;
  logic                lrck_q, lrck_d;
  logic                dacdat_q, dacdat_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                ready_q, ready_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [SAMPLE_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic                pub_q, pub_d;
  logic [SAMPLE_W-1:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic                adc_valid_q, adc_valid_d;

  logic          tc_s, rise_s, fall_s, frame_start_s, accept_s, cap_bit_s;
  logic [CW-1:0] nxt_cnt_s, cur_k_s, nxt_k_s;

  // Divider terminal count, BCLK edge events and slot position decode
  always_comb begin
    tc_s          = (div_q == DIV_LAST);
    rise_s        = tc_s && !bclk_q;
    fall_s        = tc_s && bclk_q;
    nxt_cnt_s     = (bitcnt_q == CNT_LAST) ? '0 : bitcnt_q + CNT_ONE;
    cur_k_s       = (bitcnt_q >= SLOT_C) ? bitcnt_q - SLOT_C : bitcnt_q;
    nxt_k_s       = (nxt_cnt_s >= SLOT_C) ? nxt_cnt_s - SLOT_C : nxt_cnt_s;
    frame_start_s = fall_s && (nxt_cnt_s == '0);
    accept_s      = bus.dac_valid && ready_q;
`ifdef I2S_LOOPBACK_EN
    cap_bit_s     = loopback ? dacdat_q : aud_adcdat;
`else
    cap_bit_s     = aud_adcdat;
`endif
  end

  // Next-state logic for divider, serialiser, holding buffer and capture
  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    dacdat_d    = dacdat_q;
    bitcnt_d    = bitcnt_q;
    ready_d     = ready_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    adc_l_d     = adc_l_q;
    adc_r_d     = adc_r_q;
    underrun_d  = frame_start_s && ready_q;
    pub_d       = rise_s && lrck_q && (cur_k_s == SAMPLE_C);
    adc_valid_d = pub_q;

    if (tc_s) begin
      div_d  = '0;
      bclk_d = !bclk_q;
    end else begin
      div_d  = div_q + DIV_ONE;
    end

    // A frame start only frees a full buffer, so a same-cycle handshake never collides with it
    if (accept_s) begin
      buf_l_d = bus.dac_left;
      buf_r_d = bus.dac_right;
      ready_d = 1'b0;
    end else if (frame_start_s && !ready_q) begin
      ready_d = 1'b1;
    end else begin
      ready_d = ready_q;
    end

    if (fall_s) begin
      bitcnt_d = nxt_cnt_s;
      lrck_d   = (nxt_cnt_s >= SLOT_C);
      if (frame_start_s) begin
        tx_l_d   = ready_q ? '0 : buf_l_q;
        tx_r_d   = ready_q ? '0 : buf_r_q;
        dacdat_d = 1'b0;
      end else if ((nxt_k_s >= CNT_ONE) && (nxt_k_s <= SAMPLE_C)) begin
        if (nxt_cnt_s >= SLOT_C) begin
          dacdat_d = tx_r_q[SAMPLE_W-1];
          tx_r_d   = {tx_r_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          dacdat_d = tx_l_q[SAMPLE_W-1];
          tx_l_d   = {tx_l_q[SAMPLE_W-2:0], 1'b0};
        end
      end else begin
        dacdat_d = 1'b0;
      end
    end else begin
      bitcnt_d = bitcnt_q;
    end

    if (rise_s && (cur_k_s >= CNT_ONE) && (cur_k_s <= SAMPLE_C)) begin
      if (lrck_q) begin
        rx_r_d = {rx_r_q[SAMPLE_W-2:0], cap_bit_s};
      end else begin
        rx_l_d = {rx_l_q[SAMPLE_W-2:0], cap_bit_s};
      end
    end else begin
      rx_l_d = rx_l_q;
    end

    // Publish one clk after the last right-channel bit has been shifted in
    if (pub_q) begin
      adc_l_d = rx_l_q;
      adc_r_d = rx_r_q;
    end else begin
      adc_l_d = adc_l_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b1;
      dacdat_q    <= 1'b0;
      bitcnt_q    <= CNT_LAST;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      pub_q       <= 1'b0;
      adc_l_q     <= '0;
      adc_r_q     <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      dacdat_q    <= dacdat_d;
      bitcnt_q    <= bitcnt_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      pub_q       <= pub_d;
      adc_l_q     <= adc_l_d;
      adc_r_q     <= adc_r_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  assign aud_bclk         = bclk_q;
  assign aud_lrck         = lrck_q;
  assign aud_dacdat       = dacdat_q;
  assign bus.dac_ready    = ready_q;
  assign bus.dac_underrun = underrun_q;
  assign bus.adc_left     = adc_l_q;
  assign bus.adc_right    = adc_r_q;
  assign bus.adc_valid    = adc_valid_q;

endmodule

// File: tb/tb_i2s_audio_port.sv
// Randomised bench for i2s_audio_port (SAMPLE_W=24, SLOT_W=32, BCLK_DIV=2); the reference model
// derives every pin value from the clk count since reset release.
module tb_i2s_audio_port;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic aud_bclk, aud_lrck, aud_dacdat;
  logic aud_adcdat = 1'b0;

  i2s_audio_port_if #(.SAMPLE_W(24)) bus ();

  i2s_audio_port #(.SAMPLE_W(24), .SLOT_W(32), .BCLK_DIV(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
`ifdef I2S_LOOPBACK_EN
    .loopback   (1'b0),
`endif
    .aud_bclk   (aud_bclk),
    .aud_lrck   (aud_lrck),
    .aud_dacdat (aud_dacdat),
    .aud_adcdat (aud_adcdat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int t;
  int epoch;
  logic reached;

  logic [47:0] pq[$];
  logic [23:0] frm_l[0:15], frm_r[0:15];
  logic [23:0] src_l[0:15], src_r[0:15];
  logic [23:0] mb_l, mb_r, m_adc_l, m_adc_r;
  logic        m_ready, exp_under, exp_valid, pend;
  int          pend_f;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  function automatic int bc_at(int tt);
    if (tt < 4) return 63;
    return ((tt / 4) - 1) % 64;
  endfunction

  function automatic int fr_at(int tt);
    if (tt < 4) return 0;
    return ((tt / 4) - 1) / 64;
  endfunction

  function automatic logic exp_dac(int tt);
    int b, k;
    logic [23:0] w;
    if (tt < 4) return 1'b0;
    b = bc_at(tt);
    k = b % 32;
    w = (b >= 32) ? frm_r[fr_at(tt)] : frm_l[fr_at(tt)];
    if (k >= 1 && k <= 24) return w[24-k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ready = 1'b1; exp_under = 1'b0; exp_valid = 1'b0; pend = 1'b0; pend_f = 0;
    m_adc_l = '0; m_adc_r = '0; mb_l = '0; mb_r = '0;
    pq.delete();
    for (int i = 0; i < 16; i++) begin
      frm_l[i] = '0; frm_r[i] = '0;
      src_l[i] = 24'($urandom()); src_r[i] = 24'($urandom());
    end
  endtask

  task automatic check_reset_vals(input string sfx);
    check_val({"rst_bclk", sfx}, 32'(aud_bclk), 32'd0);
    check_val({"rst_lrck", sfx}, 32'(aud_lrck), 32'd1);
    check_val({"rst_dacdat", sfx}, 32'(aud_dacdat), 32'd0);
    check_val({"rst_ready", sfx}, 32'(bus.dac_ready), 32'd1);
    check_val({"rst_underrun", sfx}, 32'(bus.dac_underrun), 32'd0);
    check_val({"rst_adc_valid", sfx}, 32'(bus.adc_valid), 32'd0);
    check_val({"rst_adc_left", sfx}, 32'(bus.adc_left), 32'd0);
    check_val({"rst_adc_right", sfx}, 32'(bus.adc_right), 32'd0);
  endtask

  task automatic check_outputs();
    check_val("bclk", 32'(aud_bclk), 32'((t / 2) % 2));
    check_val("lrck", 32'(aud_lrck), 32'(bc_at(t) >= 32));
    check_val("dacdat", 32'(aud_dacdat), 32'(exp_dac(t)));
    check_val("dac_ready", 32'(bus.dac_ready), 32'(m_ready));
    check_val("underrun", 32'(bus.dac_underrun), 32'(exp_under));
    check_val("adc_valid", 32'(bus.adc_valid), 32'(exp_valid));
    check_val("adc_left", 32'(bus.adc_left), 32'(m_adc_l));
    check_val("adc_right", 32'(bus.adc_right), 32'(m_adc_r));
  endtask

  // Drive inputs for the next rising edge (t+1)
  task automatic drive();
    int b, k, f;
    logic [23:0] w;
    if (epoch == 0) begin
      if (t == 0) pq.push_back({24'hA5A5A5, 24'h5A5A5A});
      if (t == 300) begin
        pq.push_back({24'($urandom()), 24'($urandom())});
        pq.push_back({24'($urandom()), 24'($urandom())});
      end
      if (fr_at(t) >= 2 && fr_at(t) < 6 && pq.size() == 0 && $urandom_range(0, 63) == 0)
        pq.push_back({24'($urandom()), 24'($urandom())});
      if (fr_at(t) >= 6 && pq.size() == 0)
        pq.push_back({24'($urandom()), 24'($urandom())});
    end else begin
      if (t > 4 && pq.size() == 0 && $urandom_range(0, 31) == 0)
        pq.push_back({24'($urandom()), 24'($urandom())});
    end
    bus.dac_valid = (pq.size() > 0);
    bus.dac_left  = (pq.size() > 0) ? pq[0][47:24] : 24'h000000;
    bus.dac_right = (pq.size() > 0) ? pq[0][23:0] : 24'h000000;

    aud_adcdat = 1'($urandom());
    b = bc_at(t);
    k = b % 32;
    f = fr_at(t);
    if ((t + 1) % 4 == 2 && t >= 4 && k >= 1 && k <= 24) begin
      w = (b >= 32) ? src_r[f] : src_l[f];
      aud_adcdat = w[24-k];
    end
  endtask

  // Advance the model to the state after rising edge t
  task automatic model_update();
    logic rb;
    int f;
    rb = m_ready;
    exp_under = 1'b0;
    if (t >= 4 && t % 4 == 0 && bc_at(t) == 0) begin
      f = fr_at(t);
      if (!rb) begin
        frm_l[f] = mb_l; frm_r[f] = mb_r; m_ready = 1'b1;
      end else begin
        frm_l[f] = '0; frm_r[f] = '0; exp_under = 1'b1;
      end
    end
    if (bus.dac_valid && rb) begin
      mb_l = bus.dac_left; mb_r = bus.dac_right; m_ready = 1'b0;
      void'(pq.pop_front());
    end
    exp_valid = pend;
    if (pend) begin
      m_adc_l = src_l[pend_f]; m_adc_r = src_r[pend_f];
    end
    pend = (t % 4 == 2) && (bc_at(t - 1) == 56);
    pend_f = fr_at(t - 1);
  endtask

  initial begin
    bus.dac_valid = 1'b0; bus.dac_left = '0; bus.dac_right = '0;
    reached = 1'b0;
    epoch = 0; t = 0;
    model_reset();
    src_l[0] = 24'h123456;
    src_r[0] = 24'hFEDCBA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("_pwr");
    reset_n = 1'b1;

    for (int c = 0; c < 2100; c++) begin
      check_outputs();
      if (t >= 4 && fr_at(t) == 7 && bc_at(t) == 40) begin
        reached = 1'b1;
        break;
      end
      drive();
      @(posedge clk);
      t++;
      model_update();
      @(negedge clk);
    end
    check_val("midframe_reset_reached", 32'(reached), 32'd1);

    reset_n = 1'b0;
    #1;
    check_reset_vals("_async");
    bus.dac_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("_held");
    epoch = 1; t = 0;
    model_reset();
    reset_n = 1'b1;

    for (int c = 0; c < 800; c++) begin
      check_outputs();
      drive();
      @(posedge clk);
      t++;
      model_update();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
